// File: rtl/data_fsm.sv
// data_fsm: Moore control FSM between a character source and a send engine.
// On start it repeatedly asks the source for a character, strobes the
// transmitter once per character and waits for it to finish. A run ends
// when the source reports no more data (noMoreDone) or when MAX_CHARS
// characters have been sent (done).
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - begin a run (sampled in IDLE)
//   noMore     - source exhausted (sampled in ASK, wins over newData)
//   sendDone   - transmitter finished current character (sampled in WAITSEND)
//   newData    - source has a character ready (sampled in ASK)
//   startSend  - one-cycle send strobe (SEND)
//   wantData   - data request to source (ASK)
//   noMoreDone - one-cycle run-ended-by-exhaustion flag (NODATA)
//   done       - one-cycle run-ended-by-full flag (FULL)
module data_fsm #(
  parameter int unsigned MAX_CHARS = 198
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic noMore,
  input  logic sendDone,
  input  logic newData,
  output logic startSend,
  output logic wantData,
  output logic noMoreDone,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASK      = 3'd1,
    SEND     = 3'd2,
    WAITSEND = 3'd3,
    FULL     = 3'd4,
    NODATA   = 3'd5
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_CHARS);

  state_t     state;
  logic [7:0] charCount;

  // Output pattern for a given state: {startSend, wantData, noMoreDone, done}.
  // Outputs are loaded together with the state they belong to, so the
  // registered outputs always equal the Moore decode of the current state.
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      SEND:    decode = 4'b1000;
      ASK:     decode = 4'b0100;
      NODATA:  decode = 4'b0010;
      FULL:    decode = 4'b0001;
      default: decode = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      charCount <= '0;
      {startSend, wantData, noMoreDone, done} <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ASK;
            charCount <= '0;
            {startSend, wantData, noMoreDone, done} <= decode(ASK);
          end
        end
        ASK: begin
          if (noMore) begin
            state <= NODATA;
            {startSend, wantData, noMoreDone, done} <= decode(NODATA);
          end else if (newData) begin
            state <= SEND;
            {startSend, wantData, noMoreDone, done} <= decode(SEND);
          end
        end
        SEND: begin
          state     <= WAITSEND;
          charCount <= charCount + 8'd1;
          {startSend, wantData, noMoreDone, done} <= decode(WAITSEND);
        end
        WAITSEND: begin
          if (sendDone) begin
            if (charCount == MAX_CNT) begin
              state <= FULL;
              {startSend, wantData, noMoreDone, done} <= decode(FULL);
            end else begin
              state <= ASK;
              {startSend, wantData, noMoreDone, done} <= decode(ASK);
            end
          end
        end
        default: begin
          // FULL, NODATA and any unused encoding return to IDLE.
          state <= IDLE;
          {startSend, wantData, noMoreDone, done} <= decode(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_fsm.sv
module tb_data_fsm;

  localparam int MAXC = 198;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, noMore = 1'b0, sendDone = 1'b0, newData = 1'b0;
  logic startSend, wantData, noMoreDone, done;

  int checks = 0;
  int failures = 0;

  // Reference model: phase numbers follow the published state encoding.
  int m_phase = 0;
  int m_count = 0;

  data_fsm #(.MAX_CHARS(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .noMore(noMore),
    .sendDone(sendDone), .newData(newData), .startSend(startSend),
    .wantData(wantData), .noMoreDone(noMoreDone), .done(done)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock edge from the current inputs.
  task automatic model_edge();
    if (!rst_n) begin
      m_phase = 0; m_count = 0;
    end else if (m_phase == 0) begin
      if (start) begin m_phase = 1; m_count = 0; end
    end else if (m_phase == 1) begin
      m_phase = noMore ? 5 : (newData ? 2 : 1);
    end else if (m_phase == 2) begin
      m_phase = 3; m_count = m_count + 1;
    end else if (m_phase == 3) begin
      if (sendDone) m_phase = (m_count == MAXC) ? 4 : 1;
    end else begin
      m_phase = 0;
    end
  endtask

  // {state, charCount, startSend, wantData, noMoreDone, done}
  function automatic logic [14:0] expv();
    logic [3:0] o;
    o = {m_phase == 2, m_phase == 1, m_phase == 5, m_phase == 4};
    return {3'(m_phase), 8'(m_count), o};
  endfunction

  function automatic logic [14:0] obsv();
    return {3'(dut.state), dut.charCount, startSend, wantData, noMoreDone, done};
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic nm, input logic nd, input logic sd);
    start = s; noMore = nm; newData = nd; sendDone = sd;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0);
    rst_n = 1'b0;
    model_edge();
    #12;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obsv() !== 15'h0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obsv(), 15'h0);
      end
    end
  endtask

  task automatic test_ask_hold();
    set_in(1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0);
    checks++;
    if (obsv() !== {3'd1, 8'd0, 4'b0100}) begin
      failures++;
      $display("FAIL start_to_ask got=%h exp=%h", obsv(), {3'd1, 8'd0, 4'b0100});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obsv() !== {3'd1, 8'd0, 4'b0100}) begin
        failures++;
        $display("FAIL ask_hold cyc=%0d got=%h exp=%h", i, obsv(), {3'd1, 8'd0, 4'b0100});
      end
    end
  endtask

  // Leaves from ASK via noMore; second pass also asserts newData.
  task automatic test_nodata();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        set_in(1, 0, 0, 0); tick();
      end
      set_in(0, 1, pass == 1, 0);
      tick();
      set_in(0, 0, 0, 0);
      checks++;
      if (obsv() !== {3'd5, 8'd0, 4'b0010}) begin
        failures++;
        $display("FAIL nodata_enter pass=%0d got=%h exp=%h", pass, obsv(), {3'd5, 8'd0, 4'b0010});
      end
      tick();
      checks++;
      if (obsv() !== 15'h0) begin
        failures++;
        $display("FAIL nodata_to_idle pass=%0d got=%h exp=%h", pass, obsv(), 15'h0);
      end
    end
  endtask

  task automatic test_single_char();
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0);
    checks++;
    if (obsv() !== {3'd2, 8'd0, 4'b1000}) begin
      failures++;
      $display("FAIL send_pulse got=%h exp=%h", obsv(), {3'd2, 8'd0, 4'b1000});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obsv() !== {3'd3, 8'd1, 4'b0000}) begin
        failures++;
        $display("FAIL waitsend_hold cyc=%0d got=%h exp=%h", i, obsv(), {3'd3, 8'd1, 4'b0000});
      end
    end
    set_in(0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0);
    checks++;
    if (obsv() !== {3'd1, 8'd1, 4'b0100}) begin
      failures++;
      $display("FAIL senddone_to_ask got=%h exp=%h", obsv(), {3'd1, 8'd1, 4'b0100});
    end
    set_in(0, 1, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0);
  endtask

  // Closed-form expectation: 3 clocks per character, done on clock 3*MAXC.
  task automatic test_full_run();
    int pulses = 0;
    int done_at = -1;
    int done_cycles = 0;
    set_in(1, 0, 1, 1);
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 3 * MAXC + 20; cyc++) begin
      tick();
      if (startSend) pulses++;
      if (done) begin
        done_cycles++;
        if (done_at < 0) done_at = cyc;
      end
    end
    checks++;
    if (pulses !== MAXC) begin
      failures++;
      $display("FAIL full_pulses got=%0d exp=%0d", pulses, MAXC);
    end
    checks++;
    if (done_at !== 3 * MAXC) begin
      failures++;
      $display("FAIL full_latency got=%0d exp=%0d", done_at, 3 * MAXC);
    end
    checks++;
    if (done_cycles !== 1) begin
      failures++;
      $display("FAIL full_done_width got=%0d exp=1", done_cycles);
    end
    checks++;
    if (obsv() !== {3'd0, 8'(MAXC), 4'b0000}) begin
      failures++;
      $display("FAIL full_back_idle got=%h exp=%h", obsv(), {3'd0, 8'(MAXC), 4'b0000});
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_reset_midrun();
    int budget = 400;
    set_in(1, 0, 1, 1); tick();
    start = 1'b0;
    while (!(m_phase == 3 && m_count == 50) && budget > 0) begin
      sendDone = (m_count < 50);
      tick();
      budget--;
    end
    sendDone = 1'b0;
    checks++;
    if (obsv() !== {3'd3, 8'd50, 4'b0000}) begin
      failures++;
      $display("FAIL reach_wait50 got=%h exp=%h budget=%0d", obsv(), {3'd3, 8'd50, 4'b0000}, budget);
    end
    #2;
    rst_n = 1'b0;
    model_edge();
    #1;
    checks++;
    if (obsv() !== 15'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obsv(), 15'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_in(1, 0, 1, 0); tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (obsv() !== {3'd3, 8'd1, 4'b0000}) begin
      failures++;
      $display("FAIL restart_count got=%h exp=%h", obsv(), {3'd3, 8'd1, 4'b0000});
    end
    set_in(0, 0, 0, 1); tick();
    set_in(0, 1, 0, 0); tick(); tick();
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start    = ($urandom_range(3) == 0);
      noMore   = ($urandom_range(9) == 0);
      newData  = ($urandom_range(1) == 0);
      sendDone = ($urandom_range(2) == 0);
      tick();
      checks++;
      if (obsv() !== expv()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obsv(), expv());
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_ask_hold();
    test_nodata();
    test_single_char();
    test_full_run();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
